// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA copy scheduler.
// dma_dir_t selects the copy direction carried in each descriptor;
// dma_sched_state_t is the scheduler FSM encoding.
package dma_pkg;

    localparam int DMA_ADDR_W = 16;
    localparam int DMA_DATA_W = 32;

    typedef enum logic {
        DIR_RAM2HDD = 1'b0,
        DIR_HDD2RAM = 1'b1
    } dma_dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } dma_sched_state_t;

    // Index width for a set of n requesters, never narrower than one bit.
    function automatic int dma_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_copy_scheduler_arbiter.sv
// dma_rr_arbiter: purely combinational round-robin pick.
// Grants the first asserted request at or after rr_ptr, wrapping at NREQ.
// The pointer itself lives in the parent so the grant is only committed
// when the parent actually accepts a descriptor.
module dma_rr_arbiter
    import dma_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = dma_idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    int idx;

    // Scan requesters starting at rr_ptr and keep the first valid one.
    always_comb begin
        // NOTE: every output gets a default before the scan so no path can leave a latch.
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_copy_scheduler.sv
// dma_copy_scheduler: shares the program-RAM <-> HDD copy datapath between
// NREQ requesters. One descriptor is accepted at a time in IDLE, then one
// cell per clock is streamed from the source read port to the destination
// write port, and the requester gets a one-cycle done (or err) pulse.
//
// Optional feature macro: DMA_SCHED_BOUND_CHECK_EN
//   defined   - descriptors whose ram_pos+cells or hdd_pos+cells exceeds
//               2^ADDR_W are acknowledged and then rejected via err_pulse.
//   undefined - no check, addresses wrap modulo 2^ADDR_W, err_pulse stays 0.
//
// Write timing: read data has one cycle of latency, so the write flag and
// address are registered one cycle after the read address is issued and the
// write data is the memory's own read register steered to the other side.
module dma_copy_scheduler
    import dma_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_dir,
    input  logic [NREQ*ADDR_W-1:0]    req_ram_pos,
    input  logic [NREQ*ADDR_W-1:0]    req_hdd_pos,
    input  logic [NREQ*ADDR_W-1:0]    req_cells,
    output logic [NREQ-1:0]           done_pulse,
    output logic [NREQ-1:0]           err_pulse,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic [ADDR_W-1:0]         pram_rd_addr,
    output logic [ADDR_W-1:0]         hdd_rd_addr,
    input  logic [DATA_W-1:0]         pram_data,
    input  logic [DATA_W-1:0]         hdd_data,
    output logic                      pram_wb_flag,
    output logic                      hdd_wb_flag,
    output logic [ADDR_W-1:0]         pram_wb_addr,
    output logic [ADDR_W-1:0]         hdd_wb_addr,
    output logic [DATA_W-1:0]         pram_wb_data,
    output logic [DATA_W-1:0]         hdd_wb_data
);

    localparam int IDX_W = $clog2(NREQ);

    dma_sched_state_t  state_q;
    dma_dir_t          dir_q;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [ADDR_W-1:0] cells_q;
    logic [ADDR_W-1:0] it_q;
    logic [IDX_W-1:0]  rr_ptr;

    logic [NREQ-1:0]   arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    dma_dir_t          sel_dir;
    logic [ADDR_W-1:0] sel_ram;
    logic [ADDR_W-1:0] sel_hdd;
    logic [ADDR_W-1:0] sel_cells;
    logic              bound_err;

    logic [ADDR_W-1:0] rd_addr_cur;
    logic [ADDR_W-1:0] wr_addr_cur;

    dma_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Pull the winning requester's descriptor fields out of the packed buses.
    always_comb begin
        sel_dir   = dma_dir_t'(req_dir[arb_idx]);
        sel_ram   = req_ram_pos[arb_idx*ADDR_W +: ADDR_W];
        sel_hdd   = req_hdd_pos[arb_idx*ADDR_W +: ADDR_W];
        sel_cells = req_cells[arb_idx*ADDR_W +: ADDR_W];
    end

`ifdef DMA_SCHED_BOUND_CHECK_EN
    // One extra bit holds the end address so a copy ending exactly at the top is legal.
    localparam logic [ADDR_W:0] ADDR_LIMIT = {1'b1, {ADDR_W{1'b0}}};
    logic [ADDR_W:0] ram_end;
    logic [ADDR_W:0] hdd_end;

    // Reject descriptors that would run past the end of either address space.
    always_comb begin
        ram_end   = {1'b0, sel_ram} + {1'b0, sel_cells};
        hdd_end   = {1'b0, sel_hdd} + {1'b0, sel_cells};
        bound_err = (ram_end > ADDR_LIMIT) || (hdd_end > ADDR_LIMIT);
    end
`else
    assign bound_err = 1'b0;
`endif

    // Acceptance is zero-cycle: the arbiter's pick is acknowledged while in IDLE.
    assign req_ready = (state_q == ST_IDLE && !reset) ? arb_grant : '0;
    assign busy      = (state_q != ST_IDLE);

    assign rd_addr_cur = src_base + it_q;
    assign wr_addr_cur = dst_base + it_q;

    // Only the source side is read during RUN; the other read port idles at 0.
    assign pram_rd_addr = (state_q == ST_RUN && dir_q == DIR_RAM2HDD) ? rd_addr_cur : '0;
    assign hdd_rd_addr  = (state_q == ST_RUN && dir_q == DIR_HDD2RAM) ? rd_addr_cur : '0;

    // Write data is the other side's read register, forced to 0 when not strobing.
    assign pram_wb_data = pram_wb_flag ? hdd_data  : '0;
    assign hdd_wb_data  = hdd_wb_flag  ? pram_data : '0;

    // Scheduler FSM with registered pulses, write strobes and pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_RAM2HDD;
            src_base     <= '0;
            dst_base     <= '0;
            cells_q      <= '0;
            it_q         <= '0;
            rr_ptr       <= '0;
            grant_id     <= '0;
            done_pulse   <= '0;
            err_pulse    <= '0;
            pram_wb_flag <= 1'b0;
            pram_wb_addr <= '0;
            hdd_wb_flag  <= 1'b0;
            hdd_wb_addr  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_pulse <= '0;
            err_pulse  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_id <= arb_idx;
                        rr_ptr   <= (arb_idx == IDX_W'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                        dir_q    <= sel_dir;
                        src_base <= (sel_dir == DIR_HDD2RAM) ? sel_hdd : sel_ram;
                        dst_base <= (sel_dir == DIR_HDD2RAM) ? sel_ram : sel_hdd;
                        cells_q  <= sel_cells;
                        it_q     <= '0;
                        if (bound_err) begin
                            state_q   <= ST_ERR;
                            err_pulse <= arb_grant;
                        end else if (sel_cells == '0) begin
                            state_q    <= ST_DONE;
                            done_pulse <= arb_grant;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (dir_q == DIR_HDD2RAM) begin
                        pram_wb_flag <= 1'b1;
                        pram_wb_addr <= wr_addr_cur;
                    end else begin
                        hdd_wb_flag <= 1'b1;
                        hdd_wb_addr <= wr_addr_cur;
                    end
                    it_q <= it_q + 1'b1;
                    if (it_q == cells_q - 1'b1) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    pram_wb_flag <= 1'b0;
                    pram_wb_addr <= '0;
                    hdd_wb_flag  <= 1'b0;
                    hdd_wb_addr  <= '0;
                    done_pulse   <= NREQ'(1) << grant_id;
                    state_q      <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                ST_ERR: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_copy_scheduler.sv
// Self-checking bench for dma_copy_scheduler (NREQ=2, ADDR_W=16, DATA_W=32).
// Memories are modelled as pattern functions of the address with one cycle
// of read latency. Every accepted descriptor is expanded into the list of
// writes and the completion pulse it must produce, with cycle numbers
// relative to the accept cycle, and compared with what the monitor saw.
module tb_dma_copy_scheduler;

    localparam int NREQ = 2;

`ifdef DMA_SCHED_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_dir;
    logic [31:0] req_ram_pos;
    logic [31:0] req_hdd_pos;
    logic [31:0] req_cells;
    logic [1:0]  done_pulse;
    logic [1:0]  err_pulse;
    logic        busy;
    logic [0:0]  grant_id;
    logic [15:0] pram_rd_addr, hdd_rd_addr;
    logic [31:0] pram_data, hdd_data;
    logic        pram_wb_flag, hdd_wb_flag;
    logic [15:0] pram_wb_addr, hdd_wb_addr;
    logic [31:0] pram_wb_data, hdd_wb_data;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int idle_dirty = 0;
    int model_ptr  = 0;

    typedef struct {
        bit          pram;
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  done_idx[$];
    int  done_cyc[$];
    int  err_idx[$];
    int  err_cyc[$];

    dma_copy_scheduler #(
        .NREQ   (2),
        .ADDR_W (16),
        .DATA_W (32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dir      (req_dir),
        .req_ram_pos  (req_ram_pos),
        .req_hdd_pos  (req_hdd_pos),
        .req_cells    (req_cells),
        .done_pulse   (done_pulse),
        .err_pulse    (err_pulse),
        .busy         (busy),
        .grant_id     (grant_id),
        .pram_rd_addr (pram_rd_addr),
        .hdd_rd_addr  (hdd_rd_addr),
        .pram_data    (pram_data),
        .hdd_data     (hdd_data),
        .pram_wb_flag (pram_wb_flag),
        .hdd_wb_flag  (hdd_wb_flag),
        .pram_wb_addr (pram_wb_addr),
        .hdd_wb_addr  (hdd_wb_addr),
        .pram_wb_data (pram_wb_data),
        .hdd_wb_data  (hdd_wb_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] hdd_pat(input logic [15:0] a);
        return 32'h0000_A000 + {16'h0000, a};
    endfunction

    function automatic logic [31:0] pram_pat(input logic [15:0] a);
        return {a, ~a} ^ 32'h1357_0000;
    endfunction

    // Memory read ports: one cycle of synchronous latency.
    always @(posedge clock) begin
        pram_data <= pram_pat(pram_rd_addr);
        hdd_data  <= hdd_pat(hdd_rd_addr);
    end

    // Monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (pram_wb_flag) wq.push_back(wr_t'{1'b1, pram_wb_addr, pram_wb_data, cyc});
        if (hdd_wb_flag)  wq.push_back(wr_t'{1'b0, hdd_wb_addr, hdd_wb_data, cyc});
        if (!pram_wb_flag && (pram_wb_addr != 16'h0 || pram_wb_data != 32'h0)) idle_dirty++;
        if (!hdd_wb_flag && (hdd_wb_addr != 16'h0 || hdd_wb_data != 32'h0)) idle_dirty++;
        for (int i = 0; i < NREQ; i++) begin
            if (done_pulse[i]) begin
                done_idx.push_back(i);
                done_cyc.push_back(cyc);
            end
            if (err_pulse[i]) begin
                err_idx.push_back(i);
                err_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        wq.delete();
        done_idx.delete();
        done_cyc.delete();
        err_idx.delete();
        err_cyc.delete();
    endtask

    task automatic post(input int idx, input bit dir, input logic [15:0] ram,
                        input logic [15:0] hdd, input logic [15:0] cells);
        req_dir[idx]               = dir;
        req_ram_pos[idx*16 +: 16]  = ram;
        req_hdd_pos[idx*16 +: 16]  = hdd;
        req_cells[idx*16 +: 16]    = cells;
        req_valid[idx]             = 1'b1;
    endtask

    // Waits (bounded) for a req_ready pulse; g = -1 when none arrives.
    task automatic wait_ready(output int g, output int acc);
        g   = -1;
        acc = 0;
        for (int k = 0; k < 30 && g < 0; k++) begin
            @(negedge clock);
            if (req_ready != 2'b00) begin
                acc = cyc;
                g   = req_ready[1] ? 1 : 0;
            end
        end
        check("ready_seen", 64'(g >= 0), 64'd1);
    endtask

    // Waits (bounded) for a done pulse and checks it targets requester g.
    task automatic wait_done(input int g);
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clock);
            if (done_pulse != 2'b00) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        check("done_target", 64'(done_pulse), 64'(2'b01 << g));
        check("grant_id_track", 64'(grant_id), 64'(g));
    endtask

    // One isolated transaction from a single requester, checked against the
    // expected write list and completion derived from the descriptor.
    task automatic run_copy(input int idx, input bit dir, input logic [15:0] ram,
                            input logic [15:0] hdd, input logic [15:0] cells);
        int g, acc, exp_n;
        bit err_exp;
        logic [15:0] src, dst, a_exp;
        logic [31:0] d_exp;
        clear_log();
        post(idx, dir, ram, hdd, cells);
        wait_ready(g, acc);
        check("grant_single", 64'(g), 64'(idx));
        model_ptr = (idx + 1) % NREQ;
        @(posedge clock);
        #1;
        req_valid[idx] = 1'b0;
        step(int'(cells) + 3);

        err_exp = BOUND && ((int'(ram) + int'(cells) > 65536) || (int'(hdd) + int'(cells) > 65536));
        exp_n   = err_exp ? 0 : int'(cells);
        src     = dir ? hdd : ram;
        dst     = dir ? ram : hdd;

        check("wr_count", 64'(wq.size()), 64'(exp_n));
        for (int i = 0; i < exp_n && i < wq.size(); i++) begin
            a_exp = dst + 16'(i);
            d_exp = dir ? hdd_pat(src + 16'(i)) : pram_pat(src + 16'(i));
            check("wr_side", 64'(wq[i].pram), 64'(dir));
            check("wr_addr", 64'(wq[i].addr), 64'(a_exp));
            check("wr_data", 64'(wq[i].data), 64'(d_exp));
            check("wr_cycle", 64'(wq[i].cyc - acc), 64'(2 + i));
        end
        if (err_exp) begin
            check("err_count", 64'(err_idx.size()), 64'd1);
            check("done_count", 64'(done_idx.size()), 64'd0);
            if (err_idx.size() > 0) begin
                check("err_idx", 64'(err_idx[0]), 64'(idx));
                check("err_cycle", 64'(err_cyc[0] - acc), 64'd1);
            end
        end else begin
            check("done_count", 64'(done_idx.size()), 64'd1);
            check("err_count", 64'(err_idx.size()), 64'd0);
            if (done_idx.size() > 0) begin
                check("done_idx", 64'(done_idx[0]), 64'(idx));
                check("done_cycle", 64'(done_cyc[0] - acc),
                      64'((cells == 16'h0) ? 1 : int'(cells) + 2));
            end
        end
        check("grant_id_last", 64'(grant_id), 64'(idx));
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    // Watchdog: a hang is reported and ends the run.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, acc;
        reset       = 1'b1;
        req_valid   = '0;
        req_dir     = '0;
        req_ram_pos = '0;
        req_hdd_pos = '0;
        req_cells   = '0;

        // Reset state.
        step(2);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", 64'({req_ready, done_pulse, err_pulse}), 64'd0);
        check("rst_wb", 64'({pram_wb_flag, hdd_wb_flag, pram_wb_addr, hdd_wb_addr}), 64'd0);
        check("rst_rd", 64'({pram_rd_addr, hdd_rd_addr, grant_id}), 64'd0);
        reset = 1'b0;
        model_ptr = 0;
        step(1);

        // Contention: both requesters keep re-posting; round-robin expected.
        post(0, 1'b1, 16'h0200, 16'h0300, 16'd2);
        post(1, 1'b0, 16'h0210, 16'h0310, 16'd2);
        for (int k = 0; k < 4; k++) begin
            wait_ready(g, acc);
            check("cont_grant", 64'(g), 64'(model_ptr));
            if (g < 0) break;
            model_ptr = (g + 1) % NREQ;
            @(posedge clock);
            #1;
            req_valid[g] = 1'b0;
            wait_done(g);
            @(posedge clock);
            #1;
            req_valid[g] = 1'b1;
        end
        req_valid = '0;
        step(8);

        // Directed copies.
        run_copy(0, 1'b1, 16'h0040, 16'h0100, 16'd3);
        run_copy(1, 1'b0, 16'h0010, 16'h0020, 16'd0);
        run_copy(0, 1'b1, 16'hFFFE, 16'h0500, 16'd4);
        run_copy(1, 1'b0, 16'h1234, 16'hFFFF, 16'd2);
        run_copy(1, 1'b0, 16'hFFFC, 16'h0700, 16'd4);

        // Randomised copies.
        for (int n = 0; n < 10; n++) begin
            int          r_idx;
            bit          r_dir;
            logic [15:0] r_ram, r_hdd, r_cells;
            r_idx   = int'($urandom_range(0, 1));
            r_dir   = 1'($urandom_range(0, 1));
            r_ram   = 16'($urandom);
            r_hdd   = 16'($urandom);
            if ($urandom_range(0, 2) == 0) r_ram = 16'hFFF8 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) r_hdd = 16'hFFF8 + 16'($urandom_range(0, 7));
            r_cells = 16'($urandom_range(0, 8));
            run_copy(r_idx, r_dir, r_ram, r_hdd, r_cells);
        end

        // Reset during the third RUN cycle of a 10-cell copy from requester 0.
        clear_log();
        post(0, 1'b1, 16'h0080, 16'h0900, 16'd10);
        wait_ready(g, acc);
        check("mid_grant", 64'(g), 64'd0);
        @(posedge clock);
        #1;
        req_valid = '0;
        step(2);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_pulses", 64'({req_ready, done_pulse, err_pulse}), 64'd0);
        check("mid_rst_wb", 64'({pram_wb_flag, hdd_wb_flag, pram_wb_addr, hdd_wb_addr}), 64'd0);
        check("mid_rst_wbdata", 64'({pram_wb_data, hdd_wb_data}), 64'd0);
        check("mid_rst_rd", 64'({pram_rd_addr, hdd_rd_addr, grant_id}), 64'd0);
        step(2);
        reset = 1'b0;
        model_ptr = 0;
        step(15);
        check("mid_no_done", 64'(done_idx.size()), 64'd0);

        // Pointer returned to 0: with both valid, requester 0 wins.
        post(0, 1'b0, 16'h0100, 16'h0200, 16'd1);
        post(1, 1'b1, 16'h0300, 16'h0400, 16'd1);
        wait_ready(g, acc);
        check("post_rst_grant", 64'(g), 64'(model_ptr));
        @(posedge clock);
        #1;
        req_valid = '0;
        if (g >= 0) wait_done(g);
        step(4);

        check("idle_side_clean", 64'(idle_dirty), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dma_copy_scheduler.md
# dma_copy_scheduler

Sequences the program-RAM ↔ HDD block-copy datapath and shares it between NREQ requesters. Examples of requesters are the CPU's REQFHDD/REQFRAM path and a boot loader. Each requester posts a copy descriptor (direction, RAM base, HDD base, cell count). The block arbitrates round-robin, streams one 32-bit cell per clock through the memories' read and write ports, and pulses a per-requester completion.

## Interface
Parameters:
- NREQ, 2, number of requesters (2–8)
- ADDR_W, 16, cell address / count width
- DATA_W, 32, cell width

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a descriptor posted
- req_ready  out  NREQ  one-cycle acceptance pulse to requester i
- req_dir  in  NREQ  0 = RAM→HDD, 1 = HDD→RAM
- req_ram_pos  in  NREQ*ADDR_W  RAM base address per requester
- req_hdd_pos  in  NREQ*ADDR_W  HDD base address per requester
- req_cells  in  NREQ*ADDR_W  cell count per requester
- done_pulse  out  NREQ  one-cycle pulse when requester i's copy completes
- err_pulse  out  NREQ  one-cycle pulse when requester i's descriptor is rejected
- busy  out  1  high in every state except IDLE
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester
- pram_rd_addr, hdd_rd_addr  out  ADDR_W  source read addresses
- pram_data, hdd_data  in  DATA_W  read data, 1-cycle synchronous latency
- pram_wb_flag, hdd_wb_flag  out  1  write strobes
- pram_wb_addr, hdd_wb_addr  out  ADDR_W  write addresses
- pram_wb_data, hdd_wb_data  out  DATA_W  write data

## Operation
- States: IDLE, RUN, DRAIN, DONE, ERR.
- **IDLE:** if any req_valid is high, the arbiter picks the first valid requester at or after rr_ptr.
  - req_ready[g] is asserted combinationally for that cycle.
  - The descriptor is captured at the edge, together with grant_id=g and rr_ptr=(g+1) mod NREQ.
  - Next state: RUN if cells≠0, DONE if cells=0, ERR if the bound check fails.
- Requesters must hold their fields stable while req_valid is high. They must drop or replace req_valid after req_ready.
- **RUN:** iterator it goes 0..cells-1, incrementing one per cycle.
  - The source read address is base_src+it (mod 2^ADDR_W). The non-source read address is driven to 0.
  - At each edge, the destination write registers load: flag=1, addr=base_dst+it, data=source read data.
  - When it=cells-1, next state is DRAIN.
- **DRAIN:** the last write is visible. The write registers clear at the end of the cycle. Next state is DONE.
- **DONE:** done_pulse[grant_id]=1 for one cycle. Next state is IDLE.
- **ERR:** err_pulse[grant_id]=1 for one cycle. No write strobes are issued. Next state is IDLE.
- Only the destination side's wb_flag is ever 1. The other side's wb_flag, wb_addr and wb_data stay 0.
- New requests are never accepted outside IDLE. A requester may re-post immediately after its done or err pulse.
- **Reset, including mid-transfer:**
  - The state returns to IDLE and any in-flight copy is abandoned. No done_pulse is issued for it.
  - rr_ptr=0, and all outputs are 0.

## Timing
- Acceptance: in the same cycle req_valid is seen in IDLE (zero-cycle ready).
- N-cell copy: the first write strobe appears 2 cycles after the accept cycle, and the last write N+1 cycles after it.
  - done_pulse follows N+2 cycles after the accept cycle.
  - The next acceptance is possible N+3 cycles after the accept cycle.
- Throughput is 1 cell/cycle. With zero-length or rejected descriptors, done_pulse or err_pulse appears 1 cycle after accept.
- Simultaneous valids are resolved by rr_ptr only. No requester waits more than NREQ-1 grants.

## Configuration
- DMA_SCHED_BOUND_CHECK_EN defined:
  - A descriptor is rejected if ram_pos+cells or hdd_pos+cells exceeds 2^ADDR_W. The sum is computed at ADDR_W+1 bits.
  - A rejected descriptor is still acknowledged with req_ready, then goes to ERR.
- Undefined:
  - There is no check. Addresses wrap modulo 2^ADDR_W, and err_pulse is tied to 0.

## Structure
- Package dma_pkg:
  - dma_dir_t enum (DIR_RAM2HDD=0, DIR_HDD2RAM=1)
  - dma_sched_state_t enum
  - DMA_ADDR_W and DMA_DATA_W constants
- Sub-module dma_rr_arbiter:
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational. The pointer is held in the parent.

## Test plan
- **Single copy:** req0 posts HDD→RAM, hdd 0x0100, ram 0x0040, cells 3, with hdd_data = addr+0xA000. Required response:
  - pram writes to 0x40, 0x41, 0x42 with data 0xA100..0xA102 in cycles +2..+4.
  - done_pulse[0] in cycle +5.
- **Contention:** req0 and req1 assert together after reset. Required response:
  - Grant order is 0, 1, 0, 1 on repeated re-posts.
  - grant_id tracks the grants, and done pulses go to the matching index.
- **Zero length:** cells 0. Required response: req_ready, then done_pulse 1 cycle later, with no write strobe.
- **Wrap/bound:** ram_pos 0xFFFE, cells 4.
  - With DMA_SCHED_BOUND_CHECK_EN: err_pulse and no writes.
  - Without it: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Reset mid-copy:** assert reset during the 3rd RUN cycle of a 10-cell copy. Required response:
  - All outputs go to 0 immediately, with no done_pulse.
  - The next request is accepted normally, with rr_ptr back at 0.
